// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

   typedef enum logic [1:0] {
      FETCH,
      DRAIN,
      HALTED
   } fetch_state_t;

   localparam int PC_STEP      = 4;
   localparam int WORD_SHIFT   = 2;
   localparam int ENTRY_ADDR_W = 32;
   localparam int ENTRY_DATA_W = 32;

   typedef struct packed {
      logic [ENTRY_ADDR_W-1:0] pc;
      logic [ENTRY_DATA_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-side bus: instruction memory port, decode handshake, redirect and halt status.
interface fetch_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_rdata;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_instr;
   logic [ADDR_W-1:0] out_pc;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              halted;

   modport master (
      output imem_addr, out_valid, out_instr, out_pc, halted,
      input  imem_rdata, out_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_addr, out_valid, out_instr, out_pc, halted,
      output imem_rdata, out_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, instr} entries; flush wins over push, pop may coincide with either.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int  DEPTH   = 2,
   parameter type entry_t = fetch_entry_t,
   localparam int PTR_W   = $clog2(DEPTH),
   localparam int CNT_W   = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  entry_t           push_data,
   input  logic             pop,
   input  logic             flush,
   output entry_t           head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             wr_en;
   logic             rd_en;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

   always_comb begin
      wr_en    = push && (!full || pop) && !flush;
      rd_en    = pop && !empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Pointers wrap for free because DEPTH is a power of two.
         if (wr_en) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/fetch_controller.sv
// PC sequencing, prefetch queue, redirect flush and end-of-program halt.
// Optional FETCH_PERF_EN adds saturating fetched/flushed/stall counters.
module fetch_controller
   import fetch_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int                DEPTH     = 2,
   parameter int                MEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        reset,
   fetch_if.master     bus
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_flushed,
   output logic [31:0] perf_stall
`endif
);

   localparam int                CNT_W    = $clog2(DEPTH) + 1;
   localparam logic [ADDR_W-1:0] END_ADDR = ADDR_W'(MEM_WORDS << WORD_SHIFT);

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } entry_t;

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic              at_end;
   logic              pop;
   logic              push;
   entry_t            push_entry;
   entry_t            head;
   logic              q_full;
   logic              q_empty;
   logic [CNT_W-1:0]  q_count;

   fetch_queue #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_queue (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (bus.redirect_valid),
      .head      (head),
      .full      (q_full),
      .empty     (q_empty),
      .count     (q_count)
   );

   assign bus.imem_addr = fetch_pc_q;
   assign bus.out_valid = !q_empty;
   assign bus.out_pc    = head.pc;
   assign bus.out_instr = head.instr;
   assign bus.halted    = (state_q == HALTED);

   always_comb begin
      at_end           = (fetch_pc_q >= END_ADDR);
      pop              = !q_empty && bus.out_ready;
      // Redirect suppresses the push: the word at fetch_pc is on the wrong path.
      push             = (state_q == FETCH) && !at_end && (!q_full || pop) && !bus.redirect_valid;
      push_entry.pc    = fetch_pc_q;
      push_entry.instr = bus.imem_rdata;
      state_d          = state_q;
      fetch_pc_d       = fetch_pc_q;
      if (bus.redirect_valid) begin
         state_d    = FETCH;
         fetch_pc_d = bus.redirect_pc & ~ADDR_W'(3);
      end else begin
         unique case (state_q)
            FETCH: begin
               if (at_end) begin
                  state_d = DRAIN;
               end else if (push) begin
                  fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
               end
            end
            DRAIN: begin
               if (q_count == '0) begin
                  state_d = HALTED;
               end
            end
            HALTED:  state_d = HALTED;
            default: state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= FETCH;
         fetch_pc_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [31:0] perf_flushed_q, perf_flushed_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   function automatic logic [31:0] sat_add(input logic [31:0] cur, input logic [31:0] inc);
      logic [32:0] sum;
      sum = {1'b0, cur} + {1'b0, inc};
      return sum[32] ? '1 : sum[31:0];
   endfunction

   always_comb begin
      perf_fetched_d = perf_fetched_q;
      perf_flushed_d = perf_flushed_q;
      perf_stall_d   = perf_stall_q;
      if (push) begin
         perf_fetched_d = sat_add(perf_fetched_q, 32'd1);
      end
      // A head popped alongside the redirect was consumed, so it is not counted as discarded.
      if (bus.redirect_valid) begin
         perf_flushed_d = sat_add(perf_flushed_q, 32'(q_count) - 32'(pop));
      end
      if (q_full && !bus.out_ready) begin
         perf_stall_d = sat_add(perf_stall_q, 32'd1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetched_q <= '0;
         perf_flushed_q <= '0;
         perf_stall_q   <= '0;
      end else begin
         perf_fetched_q <= perf_fetched_d;
         perf_flushed_q <= perf_flushed_d;
         perf_stall_q   <= perf_stall_d;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_flushed = perf_flushed_q;
   assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed-vector bench for fetch_controller with a 14-word program.
module tb_fetch_controller;

   localparam int          ADDR_W    = 32;
   localparam int          DATA_W    = 32;
   localparam int          MEM_WORDS = 14;
   localparam logic [31:0] RESET_PC  = 32'h0;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_flushed, perf_stall;
`endif

   fetch_controller #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .RESET_PC  (RESET_PC),
      .DEPTH     (2),
      .MEM_WORDS (MEM_WORDS)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched (perf_fetched),
      .perf_flushed (perf_flushed),
      .perf_stall   (perf_stall)
`endif
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {~a[15:0], a[15:0] ^ 16'h1234};
   endfunction

   assign bus.imem_rdata = mem_word(bus.imem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset              = 1'b1;
      bus.redirect_valid = 1'b0;
      step();
      reset = 1'b0;
   endtask

   task automatic chk_head(input string name, input logic [31:0] pc);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== pc || bus.out_instr !== mem_word(pc)) begin
         errors++;
         $display("FAIL %s: valid=%0b pc=%h instr=%h, required valid=1 pc=%h instr=%h",
                  name, bus.out_valid, bus.out_pc, bus.out_instr, pc, mem_word(pc));
      end
   endtask

   task automatic wait_halted(input string name, input int budget);
      int n;
      n = 0;
      while (bus.halted !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (bus.halted !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s: halted=%0b out_valid=%0b after %0d cycles, required halted=1 out_valid=0",
                  name, bus.halted, bus.out_valid, n);
      end
   endtask

   task automatic test_reset();
      reset              = 1'b1;
      bus.out_ready      = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h40;
      step();
      bus.redirect_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.halted !== 1'b0 || bus.imem_addr !== RESET_PC) begin
         errors++;
         $display("FAIL reset_state: valid=%0b halted=%0b addr=%h, required 0 0 %h",
                  bus.out_valid, bus.halted, bus.imem_addr, RESET_PC);
      end
`ifdef FETCH_PERF_EN
      checks++;
      if (perf_fetched !== 0 || perf_flushed !== 0 || perf_stall !== 0) begin
         errors++;
         $display("FAIL reset_perf: fetched=%0d flushed=%0d stall=%0d, required 0 0 0",
                  perf_fetched, perf_flushed, perf_stall);
      end
`endif
      reset = 1'b0;
   endtask

   task automatic test_stream();
      do_reset();
      bus.out_ready = 1'b1;
      step();
      for (int i = 0; i < MEM_WORDS; i++) begin
         chk_head($sformatf("stream[%0d]", i), 32'(i * 4));
         step();
      end
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_end: out_valid=%0b pc=%h, required out_valid=0", bus.out_valid, bus.out_pc);
      end
      wait_halted("stream_halt", 2);
      checks++;
      if (bus.imem_addr !== 32'd56) begin
         errors++;
         $display("FAIL halt_addr: imem_addr=%h, required %h", bus.imem_addr, 32'd56);
      end
`ifdef FETCH_PERF_EN
      checks++;
      if (perf_fetched !== 32'd14) begin
         errors++;
         $display("FAIL stream_fetched: %0d, required 14", perf_fetched);
      end
`endif
   endtask

   task automatic test_stall();
      bus.out_ready = 1'b0;
      do_reset();
      repeat (5) step();
      chk_head("stall_head", 32'h0);
      checks++;
      if (bus.imem_addr !== 32'h8) begin
         errors++;
         $display("FAIL stall_addr: imem_addr=%h, required %h", bus.imem_addr, 32'h8);
      end
`ifdef FETCH_PERF_EN
      checks++;
      if (perf_stall !== 32'd3) begin
         errors++;
         $display("FAIL stall_count: %0d, required 3", perf_stall);
      end
`endif
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk_head($sformatf("release[%0d]", i), 32'(i * 4));
         step();
      end
   endtask

   task automatic test_redirect();
      bus.out_ready = 1'b0;
      do_reset();
      step();
      step();
      bus.out_ready = 1'b1;
      chk_head("redir_pre0", 32'h0);
      step();
      chk_head("redir_pre4", 32'h4);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h2B;
      step();
      bus.redirect_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h28) begin
         errors++;
         $display("FAIL redir_flush: valid=%0b addr=%h, required valid=0 addr=%h",
                  bus.out_valid, bus.imem_addr, 32'h28);
      end
`ifdef FETCH_PERF_EN
      checks++;
      if (perf_flushed !== 32'd1 || perf_fetched !== 32'd3) begin
         errors++;
         $display("FAIL redir_perf: flushed=%0d fetched=%0d, required 1 3", perf_flushed, perf_fetched);
      end
`endif
      step();
      for (int i = 0; i < 4; i++) begin
         chk_head($sformatf("redir_target[%0d]", i), 32'h28 + 32'(i * 4));
         step();
      end
      wait_halted("redir_halt", 3);
`ifdef FETCH_PERF_EN
      checks++;
      if (perf_fetched !== 32'd7) begin
         errors++;
         $display("FAIL redir_fetched: %0d, required 7", perf_fetched);
      end
`endif
   endtask

   task automatic test_halt_redirect();
      bus.out_ready      = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0C;
      step();
      bus.redirect_valid = 1'b0;
      checks++;
      if (bus.halted !== 1'b0 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL halt_resume: halted=%0b valid=%0b, required 0 0", bus.halted, bus.out_valid);
      end
      step();
      chk_head("resume0", 32'h0C);
      step();
      chk_head("resume1", 32'h10);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h100;
      step();
      bus.redirect_valid = 1'b0;
      step();
      checks++;
      if (bus.halted !== 1'b0 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL far_drain: halted=%0b valid=%0b, required 0 0", bus.halted, bus.out_valid);
      end
      step();
      checks++;
      if (bus.halted !== 1'b1 || bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h100) begin
         errors++;
         $display("FAIL far_halt: halted=%0b valid=%0b addr=%h, required 1 0 %h",
                  bus.halted, bus.out_valid, bus.imem_addr, 32'h100);
      end
   endtask

   task automatic test_reset_mid();
      bus.out_ready = 1'b1;
      do_reset();
      repeat (3) step();
      chk_head("mid_pre", 32'h8);
      reset              = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h20;
      step();
      reset              = 1'b0;
      bus.redirect_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.imem_addr !== RESET_PC || bus.halted !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: valid=%0b addr=%h halted=%0b, required 0 %h 0",
                  bus.out_valid, bus.imem_addr, bus.halted, RESET_PC);
      end
      step();
      chk_head("mid_restart", RESET_PC);
   endtask

   initial begin
      checks             = 0;
      errors             = 0;
      reset              = 1'b1;
      bus.out_ready      = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_halt_redirect();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
